uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver deserialising an asynchronous 8-bit frame from `rx_serial`. Frame format is: start bit (0), 8 data bits LSB first, even-parity bit, stop bit (1). It sits between the serial line pin and the downstream byte consumer. It presents each good byte with a valid flag (`rx_ready`) that the consumer clears via `rec_ready`, and flags parity failures on `error_led`.

Parameters:
- Clkperbaud, default 1250, clock cycles per bit period (≥4; even values preferred). Half-bit = Clkperbaud/2, integer division.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nRst  input  1  reset; synchronous, active-high (asserted when 1). The codebase name is kept despite the polarity.
- rx_serial  input  1  asynchronous serial line; idles high.
- rec_ready  input  1  consumer acknowledge; when 1, clears `rx_ready`.
- rx_byte  output  8  last correctly received data byte.
- rx_ready  output  1  level flag: a new valid byte is in `rx_byte`.
- error_led  output  1  1 = the last completed frame had a parity error.

Behaviour:
- Input synchroniser: `rx_serial` passes through 2 flops. All references to "rx" below mean the synchronised value; the synchroniser's reset value is 1.
- Reset (nRst=1 at a clock edge) sets:
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0;
  - rx_byte=0, rx_ready=0, error_led=0, synchroniser=1.
- Reset mid-frame aborts the frame; no outputs update from the partial frame.
- States: IDLE, START, DATAIN, PARITY, STOP, CLEAN.
- IDLE:
  - Cycle counter held at 0.
  - rx=0 → START, cycle counter=0.
- START:
  - Count Clkperbaud/2-1 cycles, then sample rx.
  - rx=0 → DATAIN, counter=0, bit index=0.
  - rx=1 → glitch; back to IDLE with no output change.
- DATAIN:
  - Every Clkperbaud cycles (mid-bit), sample rx into data bit[index], LSB first, and increment index.
  - After bit 7 is sampled → PARITY.
- PARITY:
  - After Clkperbaud cycles, sample the parity bit.
  - Compute parity_ok = (XOR of the 8 data bits) == sampled bit (even parity).
  - → STOP.
- STOP:
  - After Clkperbaud cycles, sample the stop bit.
  - Stop=1 and parity_ok: rx_byte ← data, rx_ready ← 1, error_led ← 0.
  - Stop=1 and parity bad: rx_byte unchanged, rx_ready unchanged, error_led ← 1.
  - Stop=0 (framing error): frame discarded; rx_byte, rx_ready and error_led unchanged.
  - → CLEAN.
- CLEAN:
  - One cycle; clears the counters and the shift register.
  - → IDLE. A new start bit can then be detected (the stop-bit second half is not waited out).
- rx_ready:
  - Cleared on any cycle where rec_ready=1 and no set occurs that cycle.
  - If a set and rec_ready=1 occur in the same cycle, the set wins.
  - rec_ready has no effect on the FSM. Reception continues regardless of the consumer.
  - An unread byte is overwritten by the next good frame, and rx_ready stays 1.
- Sample timing, with t0 = first cycle synchronised rx=0:
  - start sampled at t0+Clkperbaud/2-1;
  - data bit k sampled at t0+Clkperbaud/2-1+(k+1)·Clkperbaud;
  - parity sampled at +9·Clkperbaud;
  - stop sampled at +10·Clkperbaud.
  - Outputs update the cycle after the stop sample.
- Tolerance: the line may be held for any multiple of Clkperbaud per bit; the design tolerates ±40 % of half-bit drift over a frame.
- Counter width: $clog2(Clkperbaud)+1 bits; no wrap within a bit.
- Continuous rx=1 keeps the block in IDLE indefinitely. Continuous rx=0 after a frame is treated as a new start.

Test Plan:
- Reset: nRst=1 for 2 cycles with rx_serial toggling → rx_byte=0x00, rx_ready=0, error_led=0, FSM in IDLE.
- Glitch: Clkperbaud=1250; rx_serial low for 624 cycles, then high → returns to IDLE, rx_ready stays 0, and a following valid frame is received normally.
- Good frame: send 0xA5 (parity 0, stop 1) → after ≈11 bit times, rx_byte=0xA5, rx_ready=1, error_led=0.
- Handshake: after the good frame, rec_ready=1 for 1 cycle → rx_ready=0 the next cycle with rx_byte still 0xA5. Then send 0x3C while rec_ready=0 → rx_ready=1, rx_byte=0x3C.
- Parity error: send 0x01 with parity bit 0 → error_led=1, rx_byte keeps the previous value. A subsequent good 0x7E → error_led=0, rx_byte=0x7E.
- Framing error and reset: send 0x55 with stop bit 0 → no output change. Assert nRst during DATAIN of the next frame → all outputs return to 0 and no byte is delivered.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits LSB first, even parity, one stop
//               bit. Presents good bytes with a level valid flag cleared by
//               the consumer, and flags parity failures on error_led.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int Clkperbaud = 1250
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    input  logic       rec_ready,
    output logic [7:0] rx_byte,
    output logic       rx_ready,
    output logic       error_led
);

    localparam int c_CW = $clog2(Clkperbaud) + 1;
    // START entry already spends one cycle with the counter at 0, so the
    // mid-start sample lands on half-bit minus one cycle after detection.
    localparam logic [c_CW-1:0] c_START_LAST = c_CW'(Clkperbaud / 2 - 2);
    localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(Clkperbaud - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATAIN = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_CLEAN  = 3'd5;

    logic            r_sync1;
    logic            r_sync2;
    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_parity_ok;
    logic [7:0]      r_byte;
    logic            r_ready;
    logic            r_err;

    logic w_tick;
    logic w_cnt_clear;
    logic w_shift_en;
    logic w_par_sample;
    logic w_deliver;
    logic w_flag_err;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    // Sample tick: half-bit in START, full bit period elsewhere
    assign w_tick = (r_state == c_START) ? (r_cnt == c_START_LAST)
                                         : (r_cnt == c_BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (nRst) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (!r_sync2) w_next_state = c_START;
            c_START:  if (w_tick) w_next_state = r_sync2 ? c_IDLE : c_DATAIN;
            c_DATAIN: if (w_tick && (r_bit_idx == 3'd7)) w_next_state = c_PARITY;
            c_PARITY: if (w_tick) w_next_state = c_STOP;
            c_STOP:   if (w_tick) w_next_state = c_CLEAN;
            c_CLEAN:  w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        w_cnt_clear  = (r_state == c_IDLE) || (r_state == c_CLEAN) || w_tick;
        w_shift_en   = (r_state == c_DATAIN) && w_tick;
        w_par_sample = (r_state == c_PARITY) && w_tick;
        w_deliver    = (r_state == c_STOP) && w_tick && r_sync2 && r_parity_ok;
        w_flag_err   = (r_state == c_STOP) && w_tick && r_sync2 && !r_parity_ok;
    end

    // Bit-period counter, bit index, shift register and parity result
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity_ok <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clear ? '0 : r_cnt + 1'b1;
            if ((r_state == c_IDLE) || (r_state == c_CLEAN))
                r_bit_idx <= 3'd0;
            else if (w_shift_en)
                r_bit_idx <= r_bit_idx + 3'd1;
            if (r_state == c_CLEAN)
                r_shift <= 8'h00;
            else if (w_shift_en)
                r_shift <= {r_sync2, r_shift[7:1]};
            if (w_par_sample)
                r_parity_ok <= ((^r_shift) == r_sync2);
        end
    end

    // Delivered byte, valid flag (set beats consumer clear) and error flag
    always_ff @(posedge clk) begin
        if (nRst) begin
            r_byte  <= 8'h00;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_byte  <= r_shift;
                r_ready <= 1'b1;
                r_err   <= 1'b0;
            end else begin
                if (rec_ready) r_ready <= 1'b0;
                if (w_flag_err) r_err <= 1'b1;
            end
        end
    end

    assign rx_byte   = r_byte;
    assign rx_ready  = r_ready;
    assign error_led = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: frame table with expected
//               outputs, scoreboard queue, plus glitch and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 250;
    localparam int HALF = CPB / 2;

    logic       tb_clk;
    logic       nRst;
    logic       rx_serial;
    logic       rec_ready;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       error_led;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        logic       ack_after;
        logic [7:0] exp_byte;
        logic       exp_ready;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] byte_v;
        logic       ready;
        logic       err;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];

    uart_rx #(.Clkperbaud(CPB)) dut (
        .clk       (tb_clk),
        .nRst      (nRst),
        .rx_serial (rx_serial),
        .rec_ready (rec_ready),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .error_led (error_led)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold the line at a level for n clock cycles; returns just after a rising edge
    task automatic drive_bit(input logic b, input int n);
        rx_serial = b;
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    // Full frame; the stop bit is held only long enough to be sampled
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
        drive_bit(par, CPB);
        drive_bit(stop, HALF + 10);
        rx_serial = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic [7:0] partial;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1};
        vecs[3] = '{8'h7E, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0};
        vecs[4] = '{8'h4B, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};

        // Reset with the line toggling
        nRst = 1'b1; rx_serial = 1'b1; rec_ready = 1'b0;
        @(posedge tb_clk); #1;
        rx_serial = 1'b0;
        @(posedge tb_clk); #1;
        rx_serial = 1'b1;
        @(negedge tb_clk);
        check("reset_rx_byte", 32'(rx_byte), 32'h00);
        check("reset_rx_ready", 32'(rx_ready), 32'h0);
        check("reset_error_led", 32'(error_led), 32'h0);
        @(posedge tb_clk); #1;
        nRst = 1'b0;
        repeat (5) @(posedge tb_clk);
        #1;

        // Start-bit glitch one cycle short of the mid-start sample
        drive_bit(1'b0, HALF - 1);
        drive_bit(1'b1, CPB);
        @(negedge tb_clk);
        check("glitch_rx_ready", 32'(rx_ready), 32'h0);
        check("glitch_rx_byte", 32'(rx_byte), 32'h00);
        @(posedge tb_clk); #1;

        // Frame table with scoreboard
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vecs[i].exp_byte, vecs[i].exp_ready, vecs[i].exp_err});
            send_frame(vecs[i].data, (^vecs[i].data) ^ vecs[i].par_flip, vecs[i].stop);
            @(negedge tb_clk);
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("frame%0d_rx_byte", i), 32'(rx_byte), 32'(e.byte_v));
                check($sformatf("frame%0d_rx_ready", i), 32'(rx_ready), 32'(e.ready));
                check($sformatf("frame%0d_error_led", i), 32'(error_led), 32'(e.err));
            end
            @(posedge tb_clk); #1;
            if (vecs[i].ack_after) begin
                rec_ready = 1'b1;
                @(posedge tb_clk); #1;
                rec_ready = 1'b0;
                @(negedge tb_clk);
                check($sformatf("ack%0d_rx_ready", i), 32'(rx_ready), 32'h0);
                check($sformatf("ack%0d_rx_byte", i), 32'(rx_byte), 32'(vecs[i].exp_byte));
                @(posedge tb_clk); #1;
            end
        end

        // Reset in the middle of the data bits
        partial = 8'h99;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bit(partial[i], CPB);
        drive_bit(partial[3], HALF);
        nRst = 1'b1;
        rx_serial = 1'b1;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        check("midreset_rx_byte", 32'(rx_byte), 32'h00);
        check("midreset_rx_ready", 32'(rx_ready), 32'h0);
        check("midreset_error_led", 32'(error_led), 32'h0);
        @(posedge tb_clk); #1;
        nRst = 1'b0;
        repeat (12 * CPB) @(posedge tb_clk);
        @(negedge tb_clk);
        check("postreset_rx_ready", 32'(rx_ready), 32'h0);
        check("postreset_rx_byte", 32'(rx_byte), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
